branch_rs: RTL and testbench
============================

# branch_rs

Reservation station and issue scheduler for the branch comparison unit in the out-of-order core. It buffers dispatched conditional branches, captures missing operands from the two common data buses (ALU and load/store), and issues at most one ready branch per cycle to the branch unit through a registered issue port. A flush input empties it on misprediction.

## Interface
- `DEPTH`, 4: number of entries; power of two, 2..16.
- `DATA_W`, 32: operand, immediate and PC width.
- `OP_W`, 6: opcode width; matches the `OpBus` width.
- `TAG_W`, 4: rename tag width.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset; asynchronous, active-high.
- `clear`  in  1  synchronous flush; invalidates all entries.
- `in_en`  in  1  dispatch a branch this cycle.
- `in_op`  in  OP_W  branch opcode.
- `in_o_rdy`, `in_t_rdy`  in  1 each  operand value already valid.
- `in_o_val`, `in_t_val`  in  DATA_W each  operand value when ready.
- `in_o_tag`, `in_t_tag`  in  TAG_W each  producer tag when not ready.
- `in_imm`, `in_pc`  in  DATA_W each  offset and instruction address.
- `cdb_alu_en`, `cdb_ls_en`  in  1 each  broadcast valid.
- `cdb_alu_tag`, `cdb_ls_tag`  in  TAG_W each  broadcast tag.
- `cdb_alu_data`, `cdb_ls_data`  in  DATA_W each  broadcast value.
- `rs_full`  out  1  no free entry; combinational from state.
- `out_en`  out  1  issue valid; drives the branch unit work-enable.
- `out_op`  out  OP_W  issued opcode.
- `out_o`, `out_t`, `out_imm`, `out_pc`  out  DATA_W each  issued operands.

## Operation
- Per entry: valid bit, opcode, two {ready, tag, value} operand slots, imm, PC.
- Allocation: when `in_en` is high, the write goes to the lowest-index invalid entry. If `rs_full` is high, `in_en` is ignored and the entry set is unchanged. Honouring `rs_full` is the dispatcher's job.
- Wakeup: every valid, non-ready slot whose tag equals an active CDB tag captures that CDB's data and sets ready. If both CDBs match, ALU wins. Tags are unique, so this only happens on a protocol error.
- Dispatch-cycle capture: an incoming slot that is not ready and whose tag matches an active CDB in the same cycle is written as ready, with the CDB value.
- Selection: an entry is eligible when it is valid and both slots are ready, judged on state at the start of the cycle. The lowest-index eligible entry is selected. Its fields are registered onto the `out_*` ports, and the entry is invalidated at that same edge.
- A freed entry can be reallocated on the next cycle. It cannot be reallocated in the cycle it issues.
- `rs_full` is high exactly when all DEPTH entries are valid. It does not anticipate an issue in the same cycle.
- `clear` has priority over allocate, wakeup and issue. It invalidates every entry and forces `out_en` to 0 at the next edge. `out_*` data is held.

## Timing
- Reset and clear: all valid bits 0; `out_en` 0; `rs_full` 0.
- Reset only: `out_op`, `out_o`, `out_t`, `out_imm` and `out_pc` are 0.
- Minimum latency, dispatch with both operands ready to `out_en` high: 2 cycles. The write happens at edge 1, the entry is eligible in cycle 1, and issue happens at edge 2.
- CDB wakeup to issue: the tag broadcast is captured at edge N and the entry issues at edge N+1. Macro-dependent; see Configuration.
- `out_en` is a single-cycle pulse per issued branch. Back-to-back issue is supported: one branch per cycle when several entries are eligible.
- Reset asserted mid-operation clears everything immediately, without waiting for a clock edge. Entries are lost, which is acceptable because reset also clears the ROB.

## Configuration
- `BRANCH_RS_WAKEUP_BYPASS_EN`, defined:
  - An entry whose only missing operands are matched by an active CDB in the current cycle is eligible in that cycle.
  - The matching CDB data is muxed directly into `out_o`/`out_t`.
  - CDB-to-issue latency is one edge.
  - Eligible entries that are already ready keep index priority together with bypassed entries: lowest index still wins.
- `BRANCH_RS_WAKEUP_BYPASS_EN`, undefined:
  - Eligibility uses registered ready bits only.
  - CDB-to-issue latency is two edges.

## Test plan
- Reset check:
  - Stimulus: assert `rst` asynchronously mid-cycle while 3 entries are valid.
  - Response: `out_en` and `rs_full` drop to 0 before the next clock edge. No issue follows after release.
- Simple issue:
  - Stimulus: dispatch BEQ, o=5, t=5, imm=8, pc=0x100, both ready.
  - Response: `out_en`=1 exactly 2 cycles later with `out_o`=5, `out_t`=5, `out_imm`=8, `out_pc`=0x100, then 0.
- Wakeup:
  - Stimulus: dispatch BLT with t waiting on tag 3, then `cdb_alu` broadcasts tag 3, data 0xFFFFFFFF, 4 cycles later.
  - Response: issue with `out_t`=0xFFFFFFFF, 1 edge after the broadcast with the macro defined, 2 edges without.
- Same-cycle capture:
  - Stimulus: dispatch with o tag 7 while `cdb_ls` broadcasts tag 7, data 42.
  - Response: issues 2 cycles later with `out_o`=42.
- Full and ordering:
  - Stimulus: fill 4 entries, none ready; attempt a 5th `in_en`; then ready entries 2 and 0 in the same cycle.
  - Response: `rs_full`=1 and the 5th dispatch is dropped. Entry 0 issues, then entry 2 in the next cycle, and `rs_full` falls after the first issue.
- Flush:
  - Stimulus: assert `clear` in the same cycle an entry is eligible and `in_en` is high.
  - Response: no `out_en` follows, nothing is allocated, and `rs_full`=0.

Source files
------------

// File: rtl/branch_rs.sv
// branch_rs: reservation station and issue scheduler for the branch comparison unit.
//
// Buffers dispatched conditional branches and captures missing operands from the ALU
// and load/store common data buses. It issues at most one ready branch per cycle
// through a registered issue port. A synchronous clear empties the station on
// misprediction.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   clear               synchronous flush of all entries (highest priority)
//   in_*                dispatch port (opcode, two operands with ready/tag/value, imm, pc)
//   cdb_alu_*, cdb_ls_* common data bus broadcasts (enable, tag, data)
//   rs_full             all entries valid (combinational from state)
//   out_*               registered issue port; out_en is a one-cycle pulse per branch
//
// Optional feature: define BRANCH_RS_WAKEUP_BYPASS_EN to let an entry whose missing
// operands are being broadcast this cycle issue at the same edge. The CDB data is
// muxed straight into out_o/out_t.

module branch_rs #(
   parameter int unsigned DEPTH  = 4,
   parameter int unsigned DATA_W = 32,
   parameter int unsigned OP_W   = 6,
   parameter int unsigned TAG_W  = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clear,
   input  logic              in_en,
   input  logic [OP_W-1:0]   in_op,
   input  logic              in_o_rdy,
   input  logic              in_t_rdy,
   input  logic [DATA_W-1:0] in_o_val,
   input  logic [DATA_W-1:0] in_t_val,
   input  logic [TAG_W-1:0]  in_o_tag,
   input  logic [TAG_W-1:0]  in_t_tag,
   input  logic [DATA_W-1:0] in_imm,
   input  logic [DATA_W-1:0] in_pc,
   input  logic              cdb_alu_en,
   input  logic              cdb_ls_en,
   input  logic [TAG_W-1:0]  cdb_alu_tag,
   input  logic [TAG_W-1:0]  cdb_ls_tag,
   input  logic [DATA_W-1:0] cdb_alu_data,
   input  logic [DATA_W-1:0] cdb_ls_data,
   output logic              rs_full,
   output logic              out_en,
   output logic [OP_W-1:0]   out_op,
   output logic [DATA_W-1:0] out_o,
   output logic [DATA_W-1:0] out_t,
   output logic [DATA_W-1:0] out_imm,
   output logic [DATA_W-1:0] out_pc
);

   localparam int unsigned IdxW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   // Entry state
   logic [DEPTH-1:0]  valid_q, valid_d;
   logic [DEPTH-1:0]  o_rdy_q, o_rdy_d, t_rdy_q, t_rdy_d;
   logic [OP_W-1:0]   op_q    [DEPTH];
   logic [OP_W-1:0]   op_d    [DEPTH];
   logic [TAG_W-1:0]  o_tag_q [DEPTH];
   logic [TAG_W-1:0]  o_tag_d [DEPTH];
   logic [TAG_W-1:0]  t_tag_q [DEPTH];
   logic [TAG_W-1:0]  t_tag_d [DEPTH];
   logic [DATA_W-1:0] o_val_q [DEPTH];
   logic [DATA_W-1:0] o_val_d [DEPTH];
   logic [DATA_W-1:0] t_val_q [DEPTH];
   logic [DATA_W-1:0] t_val_d [DEPTH];
   logic [DATA_W-1:0] imm_q   [DEPTH];
   logic [DATA_W-1:0] imm_d   [DEPTH];
   logic [DATA_W-1:0] pc_q    [DEPTH];
   logic [DATA_W-1:0] pc_d    [DEPTH];

   // Issue register
   logic              out_en_q, out_en_d;
   logic [OP_W-1:0]   out_op_q, out_op_d;
   logic [DATA_W-1:0] out_o_q, out_o_d, out_t_q, out_t_d, out_imm_q, out_imm_d;
   logic [DATA_W-1:0] out_pc_q, out_pc_d;

   // Wakeup, selection and allocation
   logic [DEPTH-1:0]  o_hit, t_hit, elig;
   logic [DATA_W-1:0] o_cdb [DEPTH];
   logic [DATA_W-1:0] t_cdb [DEPTH];
   logic              sel_vld;
   logic [IdxW-1:0]   sel_idx, alloc_idx;
   logic [DATA_W-1:0] sel_o, sel_t;
   logic              in_o_alu, in_o_ls, in_t_alu, in_t_ls;

   assign rs_full = &valid_q;

   // Per-entry CDB match; ALU wins when both buses match the same tag.
   always_comb begin
      for (int i = 0; i < int'(DEPTH); i++) begin
         o_hit[i] = valid_q[i] & ~o_rdy_q[i] &
                    ((cdb_alu_en & (o_tag_q[i] == cdb_alu_tag)) |
                     (cdb_ls_en & (o_tag_q[i] == cdb_ls_tag)));
         t_hit[i] = valid_q[i] & ~t_rdy_q[i] &
                    ((cdb_alu_en & (t_tag_q[i] == cdb_alu_tag)) |
                     (cdb_ls_en & (t_tag_q[i] == cdb_ls_tag)));
         o_cdb[i] = (cdb_alu_en && (o_tag_q[i] == cdb_alu_tag)) ? cdb_alu_data : cdb_ls_data;
         t_cdb[i] = (cdb_alu_en && (t_tag_q[i] == cdb_alu_tag)) ? cdb_alu_data : cdb_ls_data;
      end
   end

`ifdef BRANCH_RS_WAKEUP_BYPASS_EN
   assign elig = valid_q & (o_rdy_q | o_hit) & (t_rdy_q | t_hit);
`else
   assign elig = valid_q & o_rdy_q & t_rdy_q;
`endif

   // Lowest-index priority for both issue selection and allocation
   always_comb begin
      sel_vld   = 1'b0;
      sel_idx   = '0;
      alloc_idx = '0;
      for (int i = int'(DEPTH) - 1; i >= 0; i--) begin
         if (elig[i]) begin
            sel_vld = 1'b1;
            sel_idx = IdxW'(i);
         end
         if (!valid_q[i]) begin
            alloc_idx = IdxW'(i);
         end
      end
   end

   always_comb begin
      sel_o = o_val_q[sel_idx];
      sel_t = t_val_q[sel_idx];
`ifdef BRANCH_RS_WAKEUP_BYPASS_EN
      // A selected entry that is not yet ready can only be one woken this cycle.
      if (!o_rdy_q[sel_idx]) sel_o = o_cdb[sel_idx];
      if (!t_rdy_q[sel_idx]) sel_t = t_cdb[sel_idx];
`endif
   end

   // Dispatch-cycle capture of a broadcast that matches an incoming slot
   assign in_o_alu = cdb_alu_en & (in_o_tag == cdb_alu_tag);
   assign in_o_ls  = cdb_ls_en & (in_o_tag == cdb_ls_tag);
   assign in_t_alu = cdb_alu_en & (in_t_tag == cdb_alu_tag);
   assign in_t_ls  = cdb_ls_en & (in_t_tag == cdb_ls_tag);

   always_comb begin
      valid_d = valid_q;
      o_rdy_d = o_rdy_q;
      t_rdy_d = t_rdy_q;
      op_d    = op_q;
      o_tag_d = o_tag_q;
      t_tag_d = t_tag_q;
      o_val_d = o_val_q;
      t_val_d = t_val_q;
      imm_d   = imm_q;
      pc_d    = pc_q;

      for (int i = 0; i < int'(DEPTH); i++) begin
         if (o_hit[i]) begin
            o_rdy_d[i] = 1'b1;
            o_val_d[i] = o_cdb[i];
         end
         if (t_hit[i]) begin
            t_rdy_d[i] = 1'b1;
            t_val_d[i] = t_cdb[i];
         end
      end

      if (sel_vld) valid_d[sel_idx] = 1'b0;

      // alloc_idx points at an entry that was free at the start of the cycle, so it
      // never collides with the entry being issued.
      if (in_en && !rs_full) begin
         valid_d[alloc_idx] = 1'b1;
         op_d[alloc_idx]    = in_op;
         o_tag_d[alloc_idx] = in_o_tag;
         t_tag_d[alloc_idx] = in_t_tag;
         imm_d[alloc_idx]   = in_imm;
         pc_d[alloc_idx]    = in_pc;
         o_rdy_d[alloc_idx] = in_o_rdy | in_o_alu | in_o_ls;
         t_rdy_d[alloc_idx] = in_t_rdy | in_t_alu | in_t_ls;
         o_val_d[alloc_idx] = in_o_rdy ? in_o_val : (in_o_alu ? cdb_alu_data : cdb_ls_data);
         t_val_d[alloc_idx] = in_t_rdy ? in_t_val : (in_t_alu ? cdb_alu_data : cdb_ls_data);
      end

      if (clear) valid_d = '0;
   end

   always_comb begin
      out_en_d  = sel_vld & ~clear;
      out_op_d  = out_op_q;
      out_o_d   = out_o_q;
      out_t_d   = out_t_q;
      out_imm_d = out_imm_q;
      out_pc_d  = out_pc_q;
      if (sel_vld && !clear) begin
         out_op_d  = op_q[sel_idx];
         out_o_d   = sel_o;
         out_t_d   = sel_t;
         out_imm_d = imm_q[sel_idx];
         out_pc_d  = pc_q[sel_idx];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_q   <= '0;
         o_rdy_q   <= '0;
         t_rdy_q   <= '0;
         out_en_q  <= 1'b0;
         out_op_q  <= '0;
         out_o_q   <= '0;
         out_t_q   <= '0;
         out_imm_q <= '0;
         out_pc_q  <= '0;
      end else begin
         valid_q   <= valid_d;
         o_rdy_q   <= o_rdy_d;
         t_rdy_q   <= t_rdy_d;
         out_en_q  <= out_en_d;
         out_op_q  <= out_op_d;
         out_o_q   <= out_o_d;
         out_t_q   <= out_t_d;
         out_imm_q <= out_imm_d;
         out_pc_q  <= out_pc_d;
      end
   end

   // Payload is qualified by valid/ready bits, so it needs no reset.
   always_ff @(posedge clk) begin
      op_q    <= op_d;
      o_tag_q <= o_tag_d;
      t_tag_q <= t_tag_d;
      o_val_q <= o_val_d;
      t_val_q <= t_val_d;
      imm_q   <= imm_d;
      pc_q    <= pc_d;
   end

   assign out_en  = out_en_q;
   assign out_op  = out_op_q;
   assign out_o   = out_o_q;
   assign out_t   = out_t_q;
   assign out_imm = out_imm_q;
   assign out_pc  = out_pc_q;

endmodule

// File: tb/tb_branch_rs.sv
// tb_branch_rs: directed self-checking bench for branch_rs with an issue scoreboard.
// Expected issues (fields plus issue cycle) are queued when stimulus is driven and
// popped when out_en is seen. Any out_en with an empty queue is an error.

module tb_branch_rs;

   logic        clk = 1'b0;
   logic        rst;
   logic        clear;
   logic        in_en;
   logic [5:0]  in_op;
   logic        in_o_rdy, in_t_rdy;
   logic [31:0] in_o_val, in_t_val;
   logic [3:0]  in_o_tag, in_t_tag;
   logic [31:0] in_imm, in_pc;
   logic        cdb_alu_en, cdb_ls_en;
   logic [3:0]  cdb_alu_tag, cdb_ls_tag;
   logic [31:0] cdb_alu_data, cdb_ls_data;
   logic        rs_full, out_en;
   logic [5:0]  out_op;
   logic [31:0] out_o, out_t, out_imm, out_pc;

`ifdef BRANCH_RS_WAKEUP_BYPASS_EN
   localparam int WakeLat = 1;
`else
   localparam int WakeLat = 2;
`endif

   branch_rs #(
      .DEPTH (4),
      .DATA_W(32),
      .OP_W  (6),
      .TAG_W (4)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .clear       (clear),
      .in_en       (in_en),
      .in_op       (in_op),
      .in_o_rdy    (in_o_rdy),
      .in_t_rdy    (in_t_rdy),
      .in_o_val    (in_o_val),
      .in_t_val    (in_t_val),
      .in_o_tag    (in_o_tag),
      .in_t_tag    (in_t_tag),
      .in_imm      (in_imm),
      .in_pc       (in_pc),
      .cdb_alu_en  (cdb_alu_en),
      .cdb_ls_en   (cdb_ls_en),
      .cdb_alu_tag (cdb_alu_tag),
      .cdb_ls_tag  (cdb_ls_tag),
      .cdb_alu_data(cdb_alu_data),
      .cdb_ls_data (cdb_ls_data),
      .rs_full     (rs_full),
      .out_en      (out_en),
      .out_op      (out_op),
      .out_o       (out_o),
      .out_t       (out_t),
      .out_imm     (out_imm),
      .out_pc      (out_pc)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_cmp  = 0;
   int n_fail = 0;

   typedef struct {
      logic [5:0]  op;
      logic [31:0] o;
      logic [31:0] t;
      logic [31:0] imm;
      logic [31:0] pc;
      int          cyc;
   } exp_t;

   exp_t sb[$];
   exp_t e;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic idle();
      clear        = 1'b0;
      in_en        = 1'b0;
      in_op        = '0;
      in_o_rdy     = 1'b0;
      in_t_rdy     = 1'b0;
      in_o_val     = '0;
      in_t_val     = '0;
      in_o_tag     = '0;
      in_t_tag     = '0;
      in_imm       = '0;
      in_pc        = '0;
      cdb_alu_en   = 1'b0;
      cdb_ls_en    = 1'b0;
      cdb_alu_tag  = '0;
      cdb_ls_tag   = '0;
      cdb_alu_data = '0;
      cdb_ls_data  = '0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Advance one edge, then return inputs to idle.
   task automatic step();
      tick();
      idle();
   endtask

   task automatic disp(input logic [5:0] op, input logic ordy, input logic [31:0] oval,
                       input logic [3:0] otag, input logic trdy, input logic [31:0] tval,
                       input logic [3:0] ttag, input logic [31:0] imm, input logic [31:0] pc);
      in_en    = 1'b1;
      in_op    = op;
      in_o_rdy = ordy;
      in_o_val = oval;
      in_o_tag = otag;
      in_t_rdy = trdy;
      in_t_val = tval;
      in_t_tag = ttag;
      in_imm   = imm;
      in_pc    = pc;
   endtask

   task automatic push(input logic [5:0] op, input logic [31:0] o, input logic [31:0] t,
                       input logic [31:0] imm, input logic [31:0] pc, input int lat);
      sb.push_back('{op, o, t, imm, pc, cyc + lat});
   endtask

   task automatic drain(input int max_cyc);
      for (int n = 0; n < max_cyc && sb.size() != 0; n++) step();
      chk("drain_pending", 32'(sb.size()), 32'd0);
   endtask

   // Issue monitor, sampled on the falling edge
   always @(negedge clk) begin
      if (out_en === 1'b1) begin
         if (sb.size() == 0) begin
            chk("unexpected_issue", 32'(out_en), 32'd0);
         end else begin
            e = sb.pop_front();
            chk("issue_cycle", 32'(cyc), 32'(e.cyc));
            chk("issue_op", 32'(out_op), 32'(e.op));
            chk("issue_o", out_o, e.o);
            chk("issue_t", out_t, e.t);
            chk("issue_imm", out_imm, e.imm);
            chk("issue_pc", out_pc, e.pc);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL timeout: bench did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      rst = 1'b1;
      idle();
      repeat (3) tick();
      chk("rst_out_en", 32'(out_en), 32'd0);
      chk("rst_rs_full", 32'(rs_full), 32'd0);
      chk("rst_out_op", 32'(out_op), 32'd0);
      chk("rst_out_o", out_o, 32'd0);
      chk("rst_out_t", out_t, 32'd0);
      chk("rst_out_imm", out_imm, 32'd0);
      chk("rst_out_pc", out_pc, 32'd0);
      rst = 1'b0;
      repeat (2) step();

      // Simple issue, both operands ready: issue two edges after dispatch
      disp(6'h01, 1'b1, 32'd5, 4'd0, 1'b1, 32'd5, 4'd0, 32'd8, 32'h100);
      push(6'h01, 32'd5, 32'd5, 32'd8, 32'h100, 2);
      step();
      chk("simple_not_early", 32'(out_en), 32'd0);
      drain(10);
      chk("simple_pulse_ends", 32'(out_en), 32'd0);

      // Wakeup of t via ALU CDB, broadcast four cycles after dispatch
      disp(6'h04, 1'b1, 32'h10, 4'd0, 1'b0, 32'd0, 4'd3, 32'hFFFF_FFF0, 32'h200);
      step();
      repeat (3) step();
      cdb_alu_en   = 1'b1;
      cdb_alu_tag  = 4'd3;
      cdb_alu_data = 32'hFFFF_FFFF;
      push(6'h04, 32'h10, 32'hFFFF_FFFF, 32'hFFFF_FFF0, 32'h200, WakeLat);
      step();
      drain(10);

      // Same-cycle capture from the load/store CDB
      disp(6'h05, 1'b0, 32'd0, 4'd7, 1'b1, 32'd9, 4'd0, 32'd4, 32'h300);
      cdb_ls_en   = 1'b1;
      cdb_ls_tag  = 4'd7;
      cdb_ls_data = 32'd42;
      push(6'h05, 32'd42, 32'd9, 32'd4, 32'h300, 2);
      step();
      drain(10);

      // Fill all four entries with o waiting on tags 8..11
      for (int k = 0; k < 4; k++) begin
         disp(6'(8 + k), 1'b0, 32'd0, 4'(8 + k), 1'b1, 32'(100 + k), 4'd0, 32'(k),
              32'(32'h400 + 4 * k));
         step();
      end
      chk("full_after_fill", 32'(rs_full), 32'd1);
      // A fifth dispatch, fully ready, must be dropped
      disp(6'h0F, 1'b1, 32'd1, 4'd0, 1'b1, 32'd1, 4'd0, 32'd0, 32'h500);
      step();
      chk("full_after_drop", 32'(rs_full), 32'd1);

      // Ready entries 0 and 2 together: entry 0 first, entry 2 next cycle
      cdb_alu_en   = 1'b1;
      cdb_alu_tag  = 4'd8;
      cdb_alu_data = 32'hA0;
      cdb_ls_en    = 1'b1;
      cdb_ls_tag   = 4'd10;
      cdb_ls_data  = 32'hA2;
      push(6'h08, 32'hA0, 32'd100, 32'd0, 32'h400, WakeLat);
      push(6'h0A, 32'hA2, 32'd102, 32'd2, 32'h408, WakeLat + 1);
      step();
      repeat (WakeLat - 1) step();
      chk("full_falls_after_issue", 32'(rs_full), 32'd0);
      drain(10);

      // Release entries 1 and 3
      cdb_alu_en   = 1'b1;
      cdb_alu_tag  = 4'd9;
      cdb_alu_data = 32'd1;
      cdb_ls_en    = 1'b1;
      cdb_ls_tag   = 4'd11;
      cdb_ls_data  = 32'd3;
      push(6'h09, 32'd1, 32'd101, 32'd1, 32'h404, WakeLat);
      push(6'h0B, 32'd3, 32'd103, 32'd3, 32'h40C, WakeLat + 1);
      step();
      drain(10);

      // Flush while an entry is eligible and a new dispatch is presented
      disp(6'h10, 1'b1, 32'h77, 4'd0, 1'b1, 32'h78, 4'd0, 32'd0, 32'h600);
      step();
      clear = 1'b1;
      disp(6'h11, 1'b1, 32'h88, 4'd0, 1'b1, 32'h89, 4'd0, 32'd0, 32'h700);
      step();
      chk("flush_out_en", 32'(out_en), 32'd0);
      chk("flush_rs_full", 32'(rs_full), 32'd0);
      chk("flush_out_o_held", out_o, 32'd3);
      repeat (5) step();
      chk("flush_no_late_issue", 32'(out_en), 32'd0);

      // Asynchronous reset mid-cycle while out_en is high and three entries wait
      for (int k = 0; k < 3; k++) begin
         disp(6'(6'h18 + k), 1'b0, 32'd0, 4'(12 + k), 1'b1, 32'd0, 4'd0, 32'd0, 32'h800);
         step();
      end
      disp(6'h20, 1'b1, 32'h55, 4'd0, 1'b1, 32'h66, 4'd0, 32'd12, 32'h900);
      push(6'h20, 32'h55, 32'h66, 32'd12, 32'h900, 2);
      step();
      chk("pre_rst_full", 32'(rs_full), 32'd1);
      step();
      @(negedge clk);
      #1;
      chk("pre_rst_out_en", 32'(out_en), 32'd1);
      rst = 1'b1;
      #1;
      chk("async_rst_out_en", 32'(out_en), 32'd0);
      chk("async_rst_rs_full", 32'(rs_full), 32'd0);
      chk("async_rst_out_o", out_o, 32'd0);
      repeat (2) tick();
      rst = 1'b0;
      // Waking the lost tags must not produce an issue
      cdb_alu_en  = 1'b1;
      cdb_alu_tag = 4'd12;
      cdb_ls_en   = 1'b1;
      cdb_ls_tag  = 4'd13;
      step();
      cdb_alu_en  = 1'b1;
      cdb_alu_tag = 4'd14;
      step();
      repeat (5) step();
      chk("post_rst_no_issue", 32'(out_en), 32'd0);
      chk("final_queue_empty", 32'(sb.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
